// File: rtl/mips_bus_ram_slave.sv
// Avalon-style memory slave for the mips_cpu_bus initiator: a data window and a boot window,
// programmable wait states, little-endian byte-lane writes and a sticky protocol/decode error flag.
module mips_bus_ram_slave #(
  parameter int unsigned WAIT_STATES    = 2,
  parameter logic [31:0] DATA_BASE      = 32'h0000_0000,
  parameter int unsigned DATA_WORDS     = 1024,
  parameter logic [31:0] BOOT_BASE      = 32'hBFC0_0000,
  parameter int unsigned BOOT_WORDS     = 256,
  parameter              DATA_INIT_FILE = "",
  parameter              BOOT_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        err
);

  localparam int unsigned DATA_AW = $clog2(DATA_WORDS);
  localparam int unsigned BOOT_AW = $clog2(BOOT_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  // The request cycle in IDLE is the first stall, so BUSY holds for WAIT_STATES cycles.
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;

  logic [31:0] data_mem [DATA_WORDS];
  logic [31:0] boot_mem [BOOT_WORDS];

  logic        req;
  logic [29:0] data_woff;
  logic [29:0] boot_woff;
  logic        data_hit;
  logic        boot_hit;
  logic        bad;
  logic        commit;
  logic [31:0] rd_next;

  assign req       = read | write;
  assign data_woff = address[31:2] - DATA_BASE[31:2];
  assign boot_woff = address[31:2] - BOOT_BASE[31:2];
  assign data_hit  = data_woff < 30'(DATA_WORDS);
  assign boot_hit  = boot_woff < 30'(BOOT_WORDS);
  assign bad       = (read & write) | (address[1:0] != 2'b00) | ~(data_hit | boot_hit);
  assign commit    = (state == ACK) & write & ~bad;

  always_comb begin
    rd_next = '0;
    if (read && !bad) begin
      rd_next = data_hit ? data_mem[data_woff[DATA_AW-1:0]]
                         : boot_mem[boot_woff[BOOT_AW-1:0]];
    end
  end

  assign waitrequest = reset & req & (state != ACK);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      readdata <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (WAIT_STATES == 0) begin
              state    <= ACK;
              readdata <= rd_next;
            end else begin
              state <= BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state <= IDLE;
            err   <= 1'b1;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= ACK;
            readdata <= rd_next;
          end
        end
        ACK: begin
          state <= IDLE;
          if (req && bad) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the arrays have no reset branch; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          if (data_hit) data_mem[data_woff[DATA_AW-1:0]][8*i +: 8] <= writedata[8*i +: 8];
          else          boot_mem[boot_woff[BOOT_AW-1:0]][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_ram_slave.sv
// Directed bench for mips_bus_ram_slave: one instance with two wait states, one with none.
module tb_mips_bus_ram_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [31:0] a_address, b_address;
  logic        a_read, a_write, b_read, b_write;
  logic [3:0]  a_byteenable, b_byteenable;
  logic [31:0] a_writedata, b_writedata;
  logic [31:0] a_readdata, b_readdata;
  logic        a_waitrequest, b_waitrequest;
  logic        a_err, b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_ram_slave #(.WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .reset(reset), .address(a_address), .read(a_read), .write(a_write),
    .byteenable(a_byteenable), .writedata(a_writedata), .readdata(a_readdata),
    .waitrequest(a_waitrequest), .err(a_err)
  );

  mips_bus_ram_slave #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .address(b_address), .read(b_read), .write(b_write),
    .byteenable(b_byteenable), .writedata(b_writedata), .readdata(b_readdata),
    .waitrequest(b_waitrequest), .err(b_err)
  );

  task automatic drive(input bit sel_b, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (sel_b) begin
      b_read = rd; b_write = wr; b_address = addr; b_byteenable = be; b_writedata = wd;
    end else begin
      a_read = rd; a_write = wr; a_address = addr; a_byteenable = be; a_writedata = wd;
    end
  endtask

  // One complete transfer; returns the number of stalled cycles and the ACK-cycle readdata.
  task automatic access(input string name, input bit sel_b, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rdata);
    bit done = 0;
    stalls = 0;
    @(negedge clk);
    drive(sel_b, rd, wr, addr, be, wd);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (sel_b ? b_waitrequest : a_waitrequest) begin
        stalls++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s: no ACK within 40 cycles, stalls=%0d", name, stalls);
    end
    rdata = sel_b ? b_readdata : a_readdata;
    @(posedge clk);
    #1;
    drive(sel_b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    a_read = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitrequest: got %b expected 0", a_waitrequest); end
    checks++; if (a_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", a_readdata); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b expected 0", a_err); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL reset_err_b: got %b expected 0", b_err); end
    a_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_boot_read();
    int st; logic [31:0] rd;
    access("boot_wr", 0, 1'b0, 1'b1, 32'hBFC0_0000, 4'hF, 32'h8C01_0004, st, rd);
    checks++; if (st !== 3) begin errors++; $display("FAIL boot_wr_stalls: got %0d expected 3", st); end
    access("boot_rd", 0, 1'b1, 1'b0, 32'hBFC0_0000, 4'h0, 32'h0, st, rd);
    checks++; if (st !== 3) begin errors++; $display("FAIL boot_rd_stalls: got %0d expected 3", st); end
    checks++; if (rd !== 32'h8C01_0004) begin errors++; $display("FAIL boot_rd_data: got %h expected 8c010004", rd); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL boot_rd_err: got %b expected 0", a_err); end
  endtask

  task automatic test_byte_lanes();
    int st; logic [31:0] rd;
    access("w1", 0, 1'b0, 1'b1, 32'h0000_0004, 4'hF, 32'h5C3A_18FC, st, rd);
    access("w2_clr", 0, 1'b0, 1'b1, 32'h0000_0008, 4'hF, 32'h0, st, rd);
    access("w2_lanes", 0, 1'b0, 1'b1, 32'h0000_0008, 4'b0101, 32'hAABB_CCDD, st, rd);
    access("r2_lanes", 0, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h00BB_00DD) begin errors++; $display("FAIL lanes_data: got %h expected 00bb00dd", rd); end
    access("w2_be0", 0, 1'b0, 1'b1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, st, rd);
    access("r2_be0", 0, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h00BB_00DD) begin errors++; $display("FAIL be0_data: got %h expected 00bb00dd", rd); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL be0_err: got %b expected 0", a_err); end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] rd, word;
    access("lw", 0, 1'b1, 1'b0, 32'h0000_0004, 4'h0, 32'h0, st, word);
    checks++; if (word !== 32'h5C3A_18FC) begin errors++; $display("FAIL lw_data: got %h expected 5c3a18fc", word); end
    access("sw", 0, 1'b0, 1'b1, 32'h0000_0008, 4'hF, word, st, rd);
    checks++; if (st !== 3) begin errors++; $display("FAIL sw_stalls: got %0d expected 3", st); end
    access("sw_rb", 0, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h5C3A_18FC) begin errors++; $display("FAIL sw_readback: got %h expected 5c3a18fc", rd); end
  endtask

  task automatic test_boundaries();
    int st; logic [31:0] rd;
    access("dlast_w", 0, 1'b0, 1'b1, 32'h0000_0FFC, 4'hF, 32'h1122_3344, st, rd);
    access("dlast_r", 0, 1'b1, 1'b0, 32'h0000_0FFC, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL data_last: got %h expected 11223344", rd); end
    access("blast_w", 0, 1'b0, 1'b1, 32'hBFC0_03FC, 4'hF, 32'h5566_7788, st, rd);
    access("blast_r", 0, 1'b1, 1'b0, 32'hBFC0_03FC, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h5566_7788) begin errors++; $display("FAIL boot_last: got %h expected 55667788", rd); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL bound_err: got %b expected 0", a_err); end
  endtask

  task automatic test_reset_mid_write();
    int st; logic [31:0] rd;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL midrst_wait: got %b expected 0", a_waitrequest); end
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    access("midrst_r", 0, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h5C3A_18FC) begin errors++; $display("FAIL midrst_data: got %h expected 5c3a18fc", rd); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", a_err); end
  endtask

  task automatic test_errors();
    int st; logic [31:0] rd;
    access("unmapped", 0, 1'b1, 1'b0, 32'h0000_1000, 4'h0, 32'h0, st, rd);
    checks++; if (st !== 3) begin errors++; $display("FAIL unmapped_stalls: got %0d expected 3", st); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_data: got %h expected 00000000", rd); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b expected 1", a_err); end
    access("misalign", 0, 1'b1, 1'b0, 32'h0000_0002, 4'h0, 32'h0, st, rd);
    checks++; if (st !== 3) begin errors++; $display("FAIL misalign_stalls: got %0d expected 3", st); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_data: got %h expected 00000000", rd); end
    access("misalign_w", 0, 1'b0, 1'b1, 32'h0000_0009, 4'hF, 32'h0, st, rd);
    access("rdwr", 0, 1'b1, 1'b1, 32'h0000_0008, 4'hF, 32'hFFFF_FFFF, st, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rdwr_data: got %h expected 00000000", rd); end
    access("boot_over", 0, 1'b1, 1'b0, 32'hBFC0_0400, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL boot_over_data: got %h expected 00000000", rd); end
    access("untouched", 0, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, st, rd);
    checks++; if (rd !== 32'h5C3A_18FC) begin errors++; $display("FAIL untouched_data: got %h expected 5c3a18fc", rd); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", a_err); end
  endtask

  task automatic test_drop();
    int st; logic [31:0] rd;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL drop_pre_err: got %b expected 0", a_err); end
    reset = 1'b1;
    @(negedge clk);
    a_address = 32'h0000_0004; a_read = 1'b1;
    @(negedge clk);
    a_read = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL drop_err: got %b expected 1", a_err); end
    checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL drop_wait: got %b expected 0", a_waitrequest); end
    access("after_drop", 0, 1'b1, 1'b0, 32'h0000_0004, 4'h0, 32'h0, st, rd);
    checks++; if (st !== 3) begin errors++; $display("FAIL after_drop_stalls: got %0d expected 3", st); end
    checks++; if (rd !== 32'h5C3A_18FC) begin errors++; $display("FAIL after_drop_data: got %h expected 5c3a18fc", rd); end
  endtask

  task automatic test_zero_wait();
    int st; logic [31:0] rd;
    access("ws0_w", 1, 1'b0, 1'b1, 32'hBFC0_0004, 4'hF, 32'h27BD_FFE8, st, rd);
    checks++; if (st !== 1) begin errors++; $display("FAIL ws0_wr_stalls: got %0d expected 1", st); end
    access("ws0_r", 1, 1'b1, 1'b0, 32'hBFC0_0004, 4'h0, 32'h0, st, rd);
    checks++; if (st !== 1) begin errors++; $display("FAIL ws0_rd_stalls: got %0d expected 1", st); end
    checks++; if (rd !== 32'h27BD_FFE8) begin errors++; $display("FAIL ws0_data: got %h expected 27bdffe8", rd); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL ws0_err: got %b expected 0", b_err); end
  endtask

  initial begin
    test_reset();
    test_boot_read();
    test_byte_lanes();
    test_back_to_back();
    test_boundaries();
    test_reset_mid_write();
    test_errors();
    test_drop();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
